// File: rtl/instruction_decode.sv
// rtl/instruction_decode.sv - decode stage with load-use, jump, redirect and halt handling
module instruction_decode #(
   parameter logic [5:0] NOP_OP  = 6'h00,
   parameter logic [5:0] LOAD_OP = 6'h10,
   parameter logic [5:0] JMP_OP  = 6'h20,
   parameter logic [5:0] HALT_OP = 6'h3F
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ins,
   input  logic [15:0] current_address,
   input  logic        ex_busy,
   input  logic        ex_redirect,
   input  logic [15:0] ex_target,
   output logic        stall,
   output logic        stall_pm,
   output logic        pc_mux_sel,
   output logic [15:0] jmp_loc,
   output logic        id_valid,
   output logic [5:0]  id_opcode,
   output logic [4:0]  id_rd,
   output logic [4:0]  id_rs1,
   output logic [4:0]  id_rs2,
   output logic [15:0] id_imm,
   output logic [15:0] id_pc,
   output logic        halted,
   output logic [15:0] bubble_cnt
);

   typedef enum logic [1:0] {RUN, LDSTALL, FLUSH, HALT} state_t;
   typedef enum logic [1:0] {ACT_HOLD, ACT_LOAD, ACT_BUBBLE} act_t;

   state_t     state;
   state_t     next_state;
   act_t       act;
   logic [5:0] opcode;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic       hazard;

   assign opcode = ins[31:26];
   assign rs1    = ins[20:16];
   assign rs2    = ins[15:11];

   // The ID register still holds the load while its consumer sits in ins.
   assign hazard = id_valid && (id_opcode == LOAD_OP) && (id_rd != 5'd0) &&
                   ((rs1 == id_rd) || (rs2 == id_rd));

   always_comb begin
      stall      = 1'b0;
      stall_pm   = 1'b0;
      pc_mux_sel = 1'b0;
      jmp_loc    = 16'h0000;
      act        = ACT_HOLD;
      next_state = state;
      if (reset) begin
         act = ACT_HOLD;
      end else if (state == HALT) begin
         stall    = 1'b1;
         stall_pm = 1'b1;
      end else if (ex_redirect) begin
         pc_mux_sel = 1'b1;
         jmp_loc    = ex_target;
         act        = ACT_BUBBLE;
         next_state = FLUSH;
      end else if (ex_busy) begin
         stall    = 1'b1;
         stall_pm = 1'b1;
      end else begin
         case (state)
            FLUSH: begin
               act        = ACT_BUBBLE;
               next_state = RUN;
            end
            LDSTALL: begin
               act        = ACT_LOAD;
               next_state = RUN;
            end
            default: begin
               if (hazard) begin
                  stall      = 1'b1;
                  stall_pm   = 1'b1;
                  act        = ACT_BUBBLE;
                  next_state = LDSTALL;
               end else if (opcode == JMP_OP) begin
                  pc_mux_sel = 1'b1;
                  jmp_loc    = ins[15:0];
                  act        = ACT_LOAD;
                  next_state = FLUSH;
               end else if (opcode == HALT_OP) begin
                  act        = ACT_BUBBLE;
                  next_state = HALT;
               end else begin
                  act = ACT_LOAD;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= RUN;
         id_valid   <= 1'b0;
         id_opcode  <= NOP_OP;
         id_rd      <= 5'd0;
         id_rs1     <= 5'd0;
         id_rs2     <= 5'd0;
         id_imm     <= 16'h0000;
         id_pc      <= 16'h0000;
         halted     <= 1'b0;
         bubble_cnt <= 16'h0000;
      end else begin
         state  <= next_state;
         halted <= (next_state == HALT);
         case (act)
            ACT_LOAD: begin
               id_valid  <= 1'b1;
               id_opcode <= opcode;
               id_rd     <= ins[25:21];
               id_rs1    <= rs1;
               id_rs2    <= rs2;
               id_imm    <= ins[15:0];
               id_pc     <= current_address;
            end
            ACT_BUBBLE: begin
               id_valid  <= 1'b0;
               id_opcode <= NOP_OP;
               id_rd     <= 5'd0;
               id_rs1    <= 5'd0;
               id_rs2    <= 5'd0;
               id_imm    <= 16'h0000;
               id_pc     <= 16'h0000;
               if (bubble_cnt != 16'hFFFF) begin
                  bubble_cnt <= bubble_cnt + 16'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_decode.sv
// tb/tb_instruction_decode.sv - randomized and directed bench for instruction_decode
module tb_instruction_decode;

   localparam logic [5:0] NOP  = 6'h00;
   localparam logic [5:0] LOAD = 6'h10;
   localparam logic [5:0] JMP  = 6'h20;
   localparam logic [5:0] HLT  = 6'h3F;
   localparam logic [5:0] ADD  = 6'h01;

   logic        clk;
   logic        reset;
   logic [31:0] ins;
   logic [15:0] current_address;
   logic        ex_busy;
   logic        ex_redirect;
   logic [15:0] ex_target;
   logic        stall;
   logic        stall_pm;
   logic        pc_mux_sel;
   logic [15:0] jmp_loc;
   logic        id_valid;
   logic [5:0]  id_opcode;
   logic [4:0]  id_rd;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic [15:0] id_imm;
   logic [15:0] id_pc;
   logic        halted;
   logic [15:0] bubble_cnt;

   instruction_decode dut (
      .clk(clk), .reset(reset), .ins(ins), .current_address(current_address),
      .ex_busy(ex_busy), .ex_redirect(ex_redirect), .ex_target(ex_target),
      .stall(stall), .stall_pm(stall_pm), .pc_mux_sel(pc_mux_sel), .jmp_loc(jmp_loc),
      .id_valid(id_valid), .id_opcode(id_opcode), .id_rd(id_rd), .id_rs1(id_rs1),
      .id_rs2(id_rs2), .id_imm(id_imm), .id_pc(id_pc), .halted(halted),
      .bubble_cnt(bubble_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec;
   int n_fail;

   // Reference pipeline view: the decode register plus "what the next cycle owes".
   logic        m_valid;
   logic [5:0]  m_op;
   logic [4:0]  m_rd, m_rs1, m_rs2;
   logic [15:0] m_imm, m_pc, m_cnt;
   logic        m_halt, m_flush, m_replay;

   logic [18:0] exp_comb, obs_comb;
   logic [70:0] exp_reg, obs_reg;

   task automatic model_reset();
      m_valid = 1'b0; m_op = NOP; m_rd = '0; m_rs1 = '0; m_rs2 = '0;
      m_imm = '0; m_pc = '0; m_cnt = '0;
      m_halt = 1'b0; m_flush = 1'b0; m_replay = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                      input logic [4:0] s1, input logic [15:0] imm);
      return {op, rd, s1, imm};
   endfunction

   task automatic apply(input logic [31:0] i, input logic [15:0] a, input logic bz,
                        input logic rd_, input logic [15:0] t);
      logic st, pm, sel, bub, ld;
      logic [15:0] loc;
      ins = i; current_address = a; ex_busy = bz; ex_redirect = rd_; ex_target = t;
      st = 0; pm = 0; sel = 0; loc = 0; bub = 0; ld = 0;
      if (m_halt) begin
         st = 1; pm = 1;
      end else if (rd_) begin
         sel = 1; loc = t; bub = 1; m_flush = 1; m_replay = 0;
      end else if (bz) begin
         st = 1; pm = 1;
      end else if (m_flush) begin
         bub = 1; m_flush = 0;
      end else if (m_replay) begin
         ld = 1; m_replay = 0;
      end else if (m_valid && m_op == LOAD && m_rd != 0 &&
                   (i[20:16] == m_rd || i[15:11] == m_rd)) begin
         st = 1; pm = 1; bub = 1; m_replay = 1;
      end else if (i[31:26] == JMP) begin
         sel = 1; loc = i[15:0]; ld = 1; m_flush = 1;
      end else if (i[31:26] == HLT) begin
         bub = 1; m_halt = 1;
      end else begin
         ld = 1;
      end
      exp_comb = {st, pm, sel, loc};
      @(negedge clk);
      obs_comb = {stall, stall_pm, pc_mux_sel, jmp_loc};
      @(posedge clk);
      #1;
      if (bub) begin
         m_valid = 0; m_op = NOP; m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_pc = 0;
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      end else if (ld) begin
         m_valid = 1; m_op = i[31:26]; m_rd = i[25:21]; m_rs1 = i[20:16];
         m_rs2 = i[15:11]; m_imm = i[15:0]; m_pc = a;
      end
      exp_reg = {m_valid, m_op, m_rd, m_rs1, m_rs2, m_imm, m_pc, m_halt, m_cnt};
      obs_reg = {id_valid, id_opcode, id_rd, id_rs1, id_rs2, id_imm, id_pc, halted, bubble_cnt};
   endtask

   task automatic test_reset();
      ins = mk(JMP, 5'd1, 5'd2, 16'h00FF); ex_redirect = 1; ex_busy = 1; ex_target = 16'hFFFF;
      #1;
      n_vec++;
      if ({stall, stall_pm, pc_mux_sel, jmp_loc} !== 19'h0) begin
         n_fail++; $display("FAIL reset_comb got %h want 0", {stall, stall_pm, pc_mux_sel, jmp_loc});
      end
      n_vec++;
      if ({id_valid, id_opcode, id_rd, id_rs1, id_rs2, id_imm, id_pc, halted, bubble_cnt} !==
          {1'b0, NOP, 70'h0} >> 0) begin
         n_fail++; $display("FAIL reset_regs got valid=%b op=%h cnt=%h", id_valid, id_opcode, bubble_cnt);
      end
      do_reset();
      apply(mk(ADD, 5'd4, 5'd5, 16'h1234), 16'h0100, 0, 0, 0);
      reset = 1'b1;
      #1;
      n_vec++;
      if (id_valid !== 1'b0 || id_pc !== 16'h0) begin
         n_fail++; $display("FAIL async_reset got valid=%b pc=%h want 0/0000", id_valid, id_pc);
      end
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_load_use();
      do_reset();
      apply(mk(LOAD, 5'd3, 5'd1, 16'h0000), 16'h0010, 0, 0, 0);
      n_vec++;
      if (obs_reg !== exp_reg || id_opcode !== LOAD) begin
         n_fail++; $display("FAIL ld_decode got %h want %h", obs_reg, exp_reg);
      end
      apply(mk(ADD, 5'd6, 5'd3, 16'h1000), 16'h0011, 0, 0, 0);
      n_vec++;
      if (obs_comb[18:17] !== 2'b11 || id_valid !== 1'b0 || bubble_cnt !== 16'd1) begin
         n_fail++; $display("FAIL ld_use_stall got st=%b valid=%b cnt=%0d want 11/0/1",
                            obs_comb[18:17], id_valid, bubble_cnt);
      end
      apply(mk(ADD, 5'd6, 5'd3, 16'h1000), 16'h0011, 0, 0, 0);
      n_vec++;
      if (obs_comb[18:17] !== 2'b00 || id_valid !== 1'b1 || id_opcode !== ADD || id_pc !== 16'h0011) begin
         n_fail++; $display("FAIL ld_use_replay got st=%b valid=%b op=%h pc=%h",
                            obs_comb[18:17], id_valid, id_opcode, id_pc);
      end
      apply(mk(LOAD, 5'd0, 5'd1, 16'h0000), 16'h0020, 0, 0, 0);
      apply(mk(ADD, 5'd2, 5'd0, 16'h0000), 16'h0021, 0, 0, 0);
      n_vec++;
      if (obs_comb[18:17] !== 2'b00 || id_valid !== 1'b1 || bubble_cnt !== 16'd1) begin
         n_fail++; $display("FAIL ld_r0 got st=%b valid=%b cnt=%0d want 00/1/1",
                            obs_comb[18:17], id_valid, bubble_cnt);
      end
   endtask

   task automatic test_jmp();
      do_reset();
      apply(mk(JMP, 5'd0, 5'd0, 16'h0040), 16'h0200, 0, 0, 0);
      n_vec++;
      if (obs_comb[16] !== 1'b1 || obs_comb[15:0] !== 16'h0040 || id_valid !== 1'b1 || id_opcode !== JMP) begin
         n_fail++; $display("FAIL jmp got sel=%b loc=%h valid=%b want 1/0040/1",
                            obs_comb[16], obs_comb[15:0], id_valid);
      end
      apply(mk(ADD, 5'd1, 5'd1, 16'h0), 16'h0201, 0, 0, 0);
      n_vec++;
      if (obs_comb !== 19'h0 || id_valid !== 1'b0 || bubble_cnt !== 16'd1) begin
         n_fail++; $display("FAIL jmp_flush got comb=%h valid=%b cnt=%0d", obs_comb, id_valid, bubble_cnt);
      end
   endtask

   task automatic test_redirect_busy();
      do_reset();
      apply(mk(ADD, 5'd7, 5'd2, 16'h0), 16'h0300, 0, 0, 0);
      apply(mk(ADD, 5'd8, 5'd2, 16'h0), 16'h0301, 1, 0, 0);
      n_vec++;
      if (obs_comb[18:17] !== 2'b11 || id_pc !== 16'h0300 || id_rd !== 5'd7 || bubble_cnt !== 16'd0) begin
         n_fail++; $display("FAIL busy_hold got st=%b pc=%h rd=%0d cnt=%0d", obs_comb[18:17], id_pc, id_rd, bubble_cnt);
      end
      apply(mk(ADD, 5'd8, 5'd2, 16'h0), 16'h0301, 1, 1, 16'h1234);
      n_vec++;
      if (obs_comb[16:0] !== {1'b1, 16'h1234} || id_valid !== 1'b0 || bubble_cnt !== 16'd1) begin
         n_fail++; $display("FAIL redirect_busy got %h valid=%b cnt=%0d", obs_comb, id_valid, bubble_cnt);
      end
      apply(mk(ADD, 5'd9, 5'd2, 16'h0), 16'h1234, 0, 0, 0);
      n_vec++;
      if (id_valid !== 1'b0 || bubble_cnt !== 16'd2) begin
         n_fail++; $display("FAIL redirect_flush got valid=%b cnt=%0d want 0/2", id_valid, bubble_cnt);
      end
      apply(mk(JMP, 5'd0, 5'd0, 16'h0080), 16'h1235, 0, 0, 0);
      reset = 1'b1; #1; model_reset(); @(posedge clk); #1; reset = 1'b0;
      apply(mk(ADD, 5'd5, 5'd2, 16'h0), 16'h0400, 0, 0, 0);
      n_vec++;
      if (id_valid !== 1'b1 || id_pc !== 16'h0400 || bubble_cnt !== 16'd0) begin
         n_fail++; $display("FAIL reset_in_flush got valid=%b pc=%h cnt=%0d", id_valid, id_pc, bubble_cnt);
      end
   endtask

   task automatic test_halt();
      int bad;
      do_reset();
      apply(mk(HLT, 5'd0, 5'd0, 16'h0), 16'h0500, 0, 0, 0);
      n_vec++;
      if (halted !== 1'b1 || id_valid !== 1'b0 || bubble_cnt !== 16'd1) begin
         n_fail++; $display("FAIL halt_entry got halted=%b valid=%b cnt=%0d", halted, id_valid, bubble_cnt);
      end
      bad = 0;
      for (int k = 0; k < 12; k++) begin
         apply($urandom, 16'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
         if (obs_comb[18:16] !== 3'b110 || halted !== 1'b1 || bubble_cnt !== 16'd1 || id_valid !== 1'b0) bad++;
      end
      n_vec++;
      if (bad != 0) begin
         n_fail++; $display("FAIL halt_hold got %0d bad cycles want 0", bad);
      end
      do_reset();
      n_vec++;
      if (halted !== 1'b0 || bubble_cnt !== 16'd0) begin
         n_fail++; $display("FAIL halt_reset got halted=%b cnt=%0d", halted, bubble_cnt);
      end
      apply(mk(ADD, 5'd1, 5'd2, 16'h0), 16'h0600, 0, 0, 0);
      n_vec++;
      if (id_valid !== 1'b1 || id_pc !== 16'h0600) begin
         n_fail++; $display("FAIL halt_resume got valid=%b pc=%h", id_valid, id_pc);
      end
   endtask

   task automatic test_random();
      logic [5:0] op;
      int sel;
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         sel = $urandom_range(0, 29);
         op = (sel < 6) ? LOAD : (sel < 9) ? JMP : (sel == 9) ? HLT : 6'($urandom);
         apply({op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 11'($urandom)},
               16'($urandom), ($urandom_range(0, 6) == 0), ($urandom_range(0, 11) == 0), 16'($urandom));
         n_vec++;
         if (obs_comb !== exp_comb) begin
            n_fail++; $display("FAIL rand_comb cycle %0d got %h want %h", k, obs_comb, exp_comb);
         end
         n_vec++;
         if (obs_reg !== exp_reg) begin
            n_fail++; $display("FAIL rand_reg cycle %0d got %h want %h", k, obs_reg, exp_reg);
         end
         if (m_halt && $urandom_range(0, 3) == 0) do_reset();
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int k = 0; k < 65540; k++) begin
         apply(32'h0, 16'h0, 0, 1, 16'h00AA);
      end
      n_vec++;
      if (bubble_cnt !== 16'hFFFF || bubble_cnt !== m_cnt) begin
         n_fail++; $display("FAIL sat got %h want ffff", bubble_cnt);
      end
      apply(32'h0, 16'h0, 0, 1, 16'h00AA);
      apply(32'h0, 16'h0, 0, 0, 16'h0);
      n_vec++;
      if (bubble_cnt !== 16'hFFFF) begin
         n_fail++; $display("FAIL sat_hold got %h want ffff", bubble_cnt);
      end
   endtask

   initial begin
      n_vec = 0; n_fail = 0;
      reset = 1'b1; ins = '0; current_address = '0; ex_busy = 0; ex_redirect = 0; ex_target = '0;
      model_reset();
      @(posedge clk);
      #1;
      test_reset();
      test_load_use();
      test_jmp();
      test_redirect_busy();
      test_halt();
      test_random();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
